data_read_rd_arbiter: RTL and testbench
=======================================

Name: data_read_rd_arbiter

Overview:
- Shares one AXI-lite read channel (AR/R) of the data_read register slave between two AXI-lite read masters, S0 and S1.
- Round-robin arbitration; one outstanding transaction at a time; responses are buffered and routed back to the owning master.
- Reads outside the configured address window are answered locally with DECERR; the slave side is never touched for them.
- Sits between the interconnect/masters and the data_read slave read ports; write channels are not handled here.

Parameters:
- ADDR_BASE, 32'h0000_0000, base address of the downstream window; must be aligned to 2**ADDR_SIZE_LOG2.
- ADDR_SIZE_LOG2, 12, window size in bytes as a power of two.

Ports:
- S_AXI_ACLK  in  1  single clock for the whole block.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- S0_AXI_ARADDR  in  32  master 0 read address.
- S0_AXI_ARVALID  in  1  master 0 address valid.
- S0_AXI_ARREADY  out  1  master 0 address accepted.
- S0_AXI_RDATA  out  32  master 0 read data.
- S0_AXI_RRESP  out  2  master 0 read response.
- S0_AXI_RVALID  out  1  master 0 response valid.
- S0_AXI_RREADY  in  1  master 0 response ready.
- S1_AXI_*  same set as S0, for master 1.
- M_AXI_ARADDR  out  32  address to data_read slave.
- M_AXI_ARVALID  out  1  address valid to slave.
- M_AXI_ARREADY  in  1  slave accepted address.
- M_AXI_RDATA  in  32  slave read data.
- M_AXI_RRESP  in  2  slave response.
- M_AXI_RVALID  in  1  slave response valid.
- M_AXI_RREADY  out  1  block ready for slave response.
- GRANT  out  2  one-hot owner of the current transaction; 0 when idle.
- BUSY  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync deassert in the surrounding design): state=IDLE, last_grant=1 (so S0 wins the first tie), all ARREADY/RVALID/M_AXI_ARVALID/M_AXI_RREADY=0, RDATA=0, RRESP=0, GRANT=0, BUSY=0.
- Reset mid-transaction abandons the transaction with no response. The downstream slave must be reset in the same domain.
- FSM states and transitions:
  - IDLE: arbitrate among asserted ARVALIDs.
    - If only one master requests, grant it. If both request, grant the master != last_grant.
    - Sx_ARREADY is asserted combinationally for the granted master in this cycle only. Latch ARADDR and owner; update last_grant.
    - Address in window (ADDR & ~(2**ADDR_SIZE_LOG2-1) == ADDR_BASE) -> ADDR.
    - Address out of window -> RESP with RDATA=0, RRESP=DECERR.
  - ADDR: M_AXI_ARVALID=1 and M_AXI_ARADDR=latched address, held stable until M_AXI_ARREADY; then -> DATA. ARVALID is never withdrawn before the handshake.
  - DATA: M_AXI_RREADY=1. On M_AXI_RVALID, register RDATA/RRESP unchanged -> RESP.
  - RESP: owner's Sx_RVALID=1 with registered RDATA/RRESP held stable; the non-owner's RVALID=0. On owner's Sx_RREADY -> IDLE.
- The non-owner's ARREADY stays 0 while not IDLE; its request is held by the master and served next.
- Latency with a zero-wait slave: Sx_RVALID rises 3 cycles after the AR handshake cycle. Out-of-window: 1 cycle. Back-to-back throughput: one read per 4 cycles minimum.
- GRANT is valid from the accept cycle+1 until RESP completes.
- RDATA/RRESP on a master port may be don't-care when its RVALID=0, but implementation drives the registered value to both ports.

Decomposition:
- Package data_read_pkg: state encoding (IDLE, ADDR, DATA, RESP), RESP constants OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
- Sub-module data_read_rr_arb2: two-request round-robin picker, inputs req[1:0] and last_grant, output one-hot gnt. Combinational.
- The last_grant register stays in the parent.

Test Plan:
- S0 reads 0x004, slave returns 0xCAFE_0001/OKAY with zero wait -> S0_RVALID 3 cycles after accept, data 0xCAFE_0001, RRESP=00; S1 ports idle.
- S0 and S1 assert ARVALID in the same cycle after reset -> S0 served first, then S1; next simultaneous pair -> S1 first (alternation). GRANT sequence 01,10,10,01.
- S1 reads 0x0000_2000 with default window -> DECERR, RDATA=0, RVALID 1 cycle after accept; M_AXI_ARVALID never asserted.
- Slave holds ARREADY low 5 cycles and RVALID 3 cycles, returns SLVERR -> ARADDR/ARVALID stable throughout; S0 gets RRESP=10.
- S0 holds RREADY low 10 cycles while S1 requests -> S0 RVALID/RDATA stable; S1_ARREADY stays 0 until S0 completes, then S1 is accepted.
- Assert S_AXI_ARESET during DATA state -> all outputs go to reset values immediately (asynchronously), GRANT=0, BUSY=0; a fresh S1 read after release completes normally.

Source files
------------

// File: rtl/data_read_pkg.sv
// Shared constants for the data_read read-channel arbiter: FSM encoding,
// AXI response codes and the address-window decode helper.
package data_read_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // True when addr falls inside the aligned 2**size_log2 byte window at base.
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input int unsigned size_log2);
    logic [31:0] mask;
    mask = (32'd1 << size_log2) - 32'd1;
    return ((addr & ~mask) == base);
  endfunction

endpackage

// File: rtl/data_read_rr_arb2.sv
// Two-request round-robin picker: on a tie the requester that was not
// granted last time wins; a lone requester always wins.
module data_read_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/data_read_rd_arbiter.sv
// Shares the data_read slave AXI-lite read channel between masters S0 and S1,
// one transaction at a time; out-of-window reads are answered locally.
module data_read_rd_arbiter
  import data_read_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter int unsigned ADDR_SIZE_LOG2 = 12
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESET,

  input  logic [31:0] S0_AXI_ARADDR,
  input  logic        S0_AXI_ARVALID,
  output logic        S0_AXI_ARREADY,
  output logic [31:0] S0_AXI_RDATA,
  output logic [1:0]  S0_AXI_RRESP,
  output logic        S0_AXI_RVALID,
  input  logic        S0_AXI_RREADY,

  input  logic [31:0] S1_AXI_ARADDR,
  input  logic        S1_AXI_ARVALID,
  output logic        S1_AXI_ARREADY,
  output logic [31:0] S1_AXI_RDATA,
  output logic [1:0]  S1_AXI_RRESP,
  output logic        S1_AXI_RVALID,
  input  logic        S1_AXI_RREADY,

  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,

  output logic [1:0]  GRANT,
  output logic        BUSY
);

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [31:0] sel_addr;
  logic        owner_rready;
  logic        idle;

  assign req  = {S1_AXI_ARVALID, S0_AXI_ARVALID};
  assign idle = (state_q == ST_IDLE);

  data_read_rr_arb2 u_rr_arb (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  assign sel_addr     = gnt[1] ? S1_AXI_ARADDR : S0_AXI_ARADDR;
  assign owner_rready = owner_q ? S1_AXI_RREADY : S0_AXI_RREADY;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          owner_d      = gnt[1];
          last_grant_d = gnt[1];
          addr_d       = sel_addr;
          if (addr_in_window(sel_addr, ADDR_BASE, ADDR_SIZE_LOG2)) begin
            state_d = ST_ADDR;
          end else begin
            // Decode miss: answer locally, the slave never sees this read.
            state_d = ST_RESP;
            rdata_d = 32'd0;
            rresp_d = RESP_DECERR;
          end
        end
      end
      ST_ADDR: begin
        if (M_AXI_ARREADY) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (M_AXI_RVALID) begin
          rdata_d = M_AXI_RDATA;
          rresp_d = M_AXI_RRESP;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (owner_rready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // last_grant resets to S1 so that S0 wins the first tie.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      addr_q       <= 32'd0;
      rdata_q      <= 32'd0;
      rresp_q      <= RESP_OKAY;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
    end
  end

  assign S0_AXI_ARREADY = idle & gnt[0];
  assign S1_AXI_ARREADY = idle & gnt[1];

  assign S0_AXI_RDATA  = rdata_q;
  assign S1_AXI_RDATA  = rdata_q;
  assign S0_AXI_RRESP  = rresp_q;
  assign S1_AXI_RRESP  = rresp_q;
  assign S0_AXI_RVALID = (state_q == ST_RESP) & ~owner_q;
  assign S1_AXI_RVALID = (state_q == ST_RESP) & owner_q;

  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = (state_q == ST_ADDR);
  assign M_AXI_RREADY  = (state_q == ST_DATA);

  assign BUSY  = ~idle;
  assign GRANT = idle ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_data_read_rd_arbiter.sv
// Directed bench for data_read_rd_arbiter: two master drivers, a configurable
// slave model and a response scoreboard checked with immediate assertions.
module tb_data_read_rd_arbiter;
  import data_read_pkg::*;

  logic        clk;
  logic        rst;

  logic [31:0] s0_araddr, s1_araddr;
  logic        s0_arvalid, s1_arvalid;
  logic        s0_arready, s1_arready;
  logic [31:0] s0_rdata, s1_rdata;
  logic [1:0]  s0_rresp, s1_rresp;
  logic        s0_rvalid, s1_rvalid;
  logic        s0_rready, s1_rready;

  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;

  logic [1:0]  grant;
  logic        busy;

  typedef struct {
    int          master;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb_q[$];

  int compared   = 0;
  int mismatched = 0;

  // slave model configuration and bookkeeping
  int          ar_wait  = 0;
  int          r_wait   = 0;
  logic [31:0] slv_base = 32'hCAFE_0005;
  logic [1:0]  slv_resp = RESP_OKAY;
  logic [31:0] exp_m_araddr = 32'd0;
  logic        ar_hs = 1'b0;
  logic        r_hs  = 1'b0;
  logic [31:0] pending_addr = 32'd0;
  int          arvalid_cycles = 0;

  data_read_rd_arbiter dut (
    .S_AXI_ACLK     (clk),
    .S_AXI_ARESET   (rst),
    .S0_AXI_ARADDR  (s0_araddr),
    .S0_AXI_ARVALID (s0_arvalid),
    .S0_AXI_ARREADY (s0_arready),
    .S0_AXI_RDATA   (s0_rdata),
    .S0_AXI_RRESP   (s0_rresp),
    .S0_AXI_RVALID  (s0_rvalid),
    .S0_AXI_RREADY  (s0_rready),
    .S1_AXI_ARADDR  (s1_araddr),
    .S1_AXI_ARVALID (s1_arvalid),
    .S1_AXI_ARREADY (s1_arready),
    .S1_AXI_RDATA   (s1_rdata),
    .S1_AXI_RRESP   (s1_rresp),
    .S1_AXI_RVALID  (s1_rvalid),
    .S1_AXI_RREADY  (s1_rready),
    .M_AXI_ARADDR   (m_araddr),
    .M_AXI_ARVALID  (m_arvalid),
    .M_AXI_ARREADY  (m_arready),
    .M_AXI_RDATA    (m_rdata),
    .M_AXI_RRESP    (m_rresp),
    .M_AXI_RVALID   (m_rvalid),
    .M_AXI_RREADY   (m_rready),
    .GRANT          (grant),
    .BUSY           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic recordFailure(input string tag);
    compared++;
    mismatched++;
    $error("[TB] FAIL %s: observed no event expected event within bound", tag);
  endtask

  function automatic logic arready_of(input int m);
    return (m == 0) ? s0_arready : s1_arready;
  endfunction

  function automatic logic rvalid_of(input int m);
    return (m == 0) ? s0_rvalid : s1_rvalid;
  endfunction

  // Drive a read request; when track is set the expected response is queued.
  task automatic applyStimulus(input int m, input logic [31:0] addr,
                               input logic [31:0] dat, input logic [1:0] resp,
                               input bit track);
    exp_t e;
    if (track) begin
      e.master = m;
      e.data   = dat;
      e.resp   = resp;
      sb_q.push_back(e);
    end
    if (m == 0) begin
      s0_araddr  = addr;
      s0_arvalid = 1'b1;
    end else begin
      s1_araddr  = addr;
      s1_arvalid = 1'b1;
    end
  endtask

  task automatic waitAccept(input int m, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (arready_of(m)) got = 1'b1;
    end
    if (!got) recordFailure({tag, "_accept"});
    @(posedge clk);
    #1;
    if (m == 0) s0_arvalid = 1'b0;
    else        s1_arvalid = 1'b0;
  endtask

  task automatic waitRvalid(input int m, output int lat);
    bit got = 1'b0;
    lat = -1;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(negedge clk);
      if (rvalid_of(m)) begin
        got = 1'b1;
        lat = i;
      end
    end
  endtask

  task automatic waitIdle(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk);
      #1;
      if (!busy) got = 1'b1;
    end
    if (!got) recordFailure({tag, "_idle"});
  endtask

  task automatic popCheck(input int m, input logic [31:0] dat, input logic [1:0] resp);
    exp_t e;
    if (sb_q.size() == 0) begin
      recordFailure("unexpected_response");
    end else begin
      e = sb_q.pop_front();
      checkOutput("resp_master", m, e.master);
      checkOutput("resp_rdata", dat, e.data);
      checkOutput("resp_rresp", resp, e.resp);
    end
  endtask

  always @(posedge clk) begin
    ar_hs <= m_arvalid && m_arready;
    r_hs  <= m_rvalid && m_rready;
    if (m_arvalid && m_arready) pending_addr <= m_araddr;
    if (m_arvalid) arvalid_cycles <= arvalid_cycles + 1;
  end

  // Slave model: ARREADY after ar_wait cycles, RVALID r_wait cycles after AR.
  initial begin
    bit rpending = 1'b0;
    int ar_cnt = 0;
    int r_cnt = 0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = 32'd0;
    m_rresp   = RESP_OKAY;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        rpending  = 1'b0;
        ar_cnt    = 0;
        r_cnt     = 0;
      end else begin
        if (r_hs) begin
          m_rvalid = 1'b0;
          rpending = 1'b0;
        end
        if (ar_hs) begin
          checkOutput("m_araddr", pending_addr, exp_m_araddr);
          m_arready = 1'b0;
          rpending  = 1'b1;
          r_cnt     = 0;
        end
        if (m_arvalid && !m_arready && !rpending) begin
          if (ar_cnt >= ar_wait) begin
            m_arready = 1'b1;
            ar_cnt    = 0;
          end else begin
            ar_cnt++;
          end
        end
        if (rpending && !m_rvalid) begin
          if (r_cnt >= r_wait) begin
            m_rvalid = 1'b1;
            m_rdata  = slv_base ^ pending_addr;
            m_rresp  = slv_resp;
          end else begin
            r_cnt++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (s0_rvalid && s0_rready) popCheck(0, s0_rdata, s0_rresp);
      if (s1_rvalid && s1_rready) popCheck(1, s1_rdata, s1_rresp);
    end
  end

  initial begin
    int lat;
    int arv_before;

    rst = 1'b1;
    s0_araddr = 32'd0; s0_arvalid = 1'b0; s0_rready = 1'b1;
    s1_araddr = 32'd0; s1_arvalid = 1'b0; s1_rready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_grant", grant, 2'b00);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_s0_rvalid", s0_rvalid, 1'b0);
    checkOutput("rst_s1_rvalid", s1_rvalid, 1'b0);
    checkOutput("rst_m_arvalid", m_arvalid, 1'b0);
    checkOutput("rst_m_rready", m_rready, 1'b0);
    checkOutput("rst_s0_rdata", s0_rdata, 32'd0);
    checkOutput("rst_s1_rresp", s1_rresp, 2'b00);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] simultaneous pair after reset");
    applyStimulus(0, 32'h010, slv_base ^ 32'h010, RESP_OKAY, 1'b1);
    applyStimulus(1, 32'h020, slv_base ^ 32'h020, RESP_OKAY, 1'b1);
    exp_m_araddr = 32'h010;
    waitAccept(0, "pair1_s0");
    checkOutput("pair1_grant0", grant, 2'b01);
    waitRvalid(0, lat);
    checkOutput("pair1_lat0", lat, 3);
    exp_m_araddr = 32'h020;
    waitAccept(1, "pair1_s1");
    checkOutput("pair1_grant1", grant, 2'b10);
    waitRvalid(1, lat);
    checkOutput("pair1_lat1", lat, 3);
    waitIdle("pair1");

    $display("[TB] single S0 read, zero-wait slave");
    @(posedge clk);
    #1;
    applyStimulus(0, 32'h004, 32'hCAFE_0001, RESP_OKAY, 1'b1);
    exp_m_araddr = 32'h004;
    waitAccept(0, "single");
    checkOutput("single_grant", grant, 2'b01);
    checkOutput("single_busy", busy, 1'b1);
    waitRvalid(0, lat);
    checkOutput("single_lat", lat, 3);
    checkOutput("single_s1_rvalid", s1_rvalid, 1'b0);
    checkOutput("single_s1_arready", s1_arready, 1'b0);
    waitIdle("single");

    $display("[TB] simultaneous pair, S1 owed the tie");
    @(posedge clk);
    #1;
    applyStimulus(1, 32'h030, slv_base ^ 32'h030, RESP_OKAY, 1'b1);
    applyStimulus(0, 32'h040, slv_base ^ 32'h040, RESP_OKAY, 1'b1);
    exp_m_araddr = 32'h030;
    waitAccept(1, "pair2_s1");
    checkOutput("pair2_grant1", grant, 2'b10);
    waitRvalid(1, lat);
    checkOutput("pair2_lat1", lat, 3);
    exp_m_araddr = 32'h040;
    waitAccept(0, "pair2_s0");
    checkOutput("pair2_grant0", grant, 2'b01);
    waitRvalid(0, lat);
    checkOutput("pair2_lat0", lat, 3);
    waitIdle("pair2");

    $display("[TB] out-of-window read");
    @(posedge clk);
    #1;
    arv_before = arvalid_cycles;
    applyStimulus(1, 32'h0000_2000, 32'd0, RESP_DECERR, 1'b1);
    waitAccept(1, "decerr");
    checkOutput("decerr_grant", grant, 2'b10);
    waitRvalid(1, lat);
    checkOutput("decerr_lat", lat, 1);
    waitIdle("decerr");
    checkOutput("decerr_no_m_arvalid", arvalid_cycles, arv_before);

    $display("[TB] stalling slave with SLVERR");
    @(posedge clk);
    #1;
    ar_wait  = 5;
    r_wait   = 3;
    slv_resp = RESP_SLVERR;
    exp_m_araddr = 32'h100;
    applyStimulus(0, 32'h100, slv_base ^ 32'h100, RESP_SLVERR, 1'b1);
    waitAccept(0, "stall");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_m_arvalid", m_arvalid, 1'b1);
      checkOutput("stall_m_araddr", m_araddr, 32'h100);
    end
    waitRvalid(0, lat);
    checkOutput("stall_lat", lat, 6);
    waitIdle("stall");
    ar_wait  = 0;
    r_wait   = 0;
    slv_resp = RESP_OKAY;

    $display("[TB] S0 withholds RREADY while S1 requests");
    @(posedge clk);
    #1;
    s0_rready = 1'b0;
    exp_m_araddr = 32'h008;
    applyStimulus(0, 32'h008, slv_base ^ 32'h008, RESP_OKAY, 1'b1);
    waitAccept(0, "hold_s0");
    waitRvalid(0, lat);
    checkOutput("hold_lat", lat, 3);
    @(posedge clk);
    #1;
    applyStimulus(1, 32'h00C, slv_base ^ 32'h00C, RESP_OKAY, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold_s0_rvalid", s0_rvalid, 1'b1);
      checkOutput("hold_s0_rdata", s0_rdata, slv_base ^ 32'h008);
      checkOutput("hold_s1_arready", s1_arready, 1'b0);
    end
    @(posedge clk);
    #1;
    s0_rready = 1'b1;
    exp_m_araddr = 32'h00C;
    waitAccept(1, "hold_s1");
    checkOutput("hold_grant1", grant, 2'b10);
    waitRvalid(1, lat);
    checkOutput("hold_lat1", lat, 3);
    waitIdle("hold");

    $display("[TB] reset during DATA");
    @(posedge clk);
    #1;
    r_wait = 20;
    exp_m_araddr = 32'h010;
    applyStimulus(0, 32'h010, 32'd0, RESP_OKAY, 1'b0);
    waitAccept(0, "midrst");
    repeat (3) @(negedge clk);
    checkOutput("midrst_m_rready_before", m_rready, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_grant", grant, 2'b00);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_m_rready", m_rready, 1'b0);
    checkOutput("midrst_m_arvalid", m_arvalid, 1'b0);
    checkOutput("midrst_s0_rvalid", s0_rvalid, 1'b0);
    checkOutput("midrst_s0_rdata", s0_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    r_wait = 0;
    @(posedge clk);
    #1;
    exp_m_araddr = 32'h014;
    applyStimulus(1, 32'h014, slv_base ^ 32'h014, RESP_OKAY, 1'b1);
    waitAccept(1, "postrst");
    checkOutput("postrst_grant", grant, 2'b10);
    waitRvalid(1, lat);
    checkOutput("postrst_lat", lat, 3);
    waitIdle("postrst");

    repeat (2) @(posedge clk);
    checkOutput("scoreboard_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
